// File: rtl/mask_row_serializer.sv
// mask_row_serializer
// Takes one IMG_W-bit row mask per handshake and shifts it out to the sensor
// mask chain as OUT_W-bit beats, lowest chunk first. Row position within the
// frame is tracked so the last chunk of a row and the last row of a frame
// can be flagged. A one-cycle pulse follows the final beat of a frame.
module mask_row_serializer #(
    parameter int IMG_W = 300,
    parameter int IMG_H = 300,
    parameter int OUT_W = 16,
    localparam int NCHUNK = (IMG_W + OUT_W - 1) / OUT_W,
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             frame_abort,
    input  logic [IMG_W-1:0] row_mask,
    input  logic             row_valid,
    output logic             row_ready,
    output logic [OUT_W-1:0] ser_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last_chunk,
    output logic             ser_last_row,
    output logic [RW-1:0]    row_idx,
    output logic             frame_done,
    output logic             busy
);

    // Shadow holds whole chunks; bits above IMG_W are padding and stay zero.
    localparam int SW = NCHUNK * OUT_W;
    localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);
    localparam logic [RW-1:0] LAST_ROW   = RW'(IMG_H - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_r;
    logic [SW-1:0]   shadow_r;
    logic [CW-1:0]   chunk_cnt_r;
    logic [RW-1:0]   row_cnt_r;
    logic            frame_done_r;

    logic            in_shift_s;
    logic            last_chunk_s;
    logic            last_row_s;

    // Decode of the registered state into the handshake and status outputs.
    always_comb begin
        in_shift_s     = (state_r == SHIFT);
        last_chunk_s   = (chunk_cnt_r == LAST_CHUNK);
        last_row_s     = (row_cnt_r == LAST_ROW);
        // rst_n gates row_ready so nothing is offered while reset is held.
        row_ready      = rst_n & clk_en & ~in_shift_s;
        ser_valid      = clk_en & in_shift_s;
        ser_data       = shadow_r[OUT_W-1:0];
        ser_last_chunk = in_shift_s & last_chunk_s;
        ser_last_row   = last_row_s;
        row_idx        = row_cnt_r;
        busy           = in_shift_s;
        // A pending pulse is withheld while the block is frozen.
        frame_done     = frame_done_r & clk_en;
    end

    // Row load / beat shift state machine with row and chunk counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            shadow_r     <= {SW{1'b0}};
            chunk_cnt_r  <= {CW{1'b0}};
            row_cnt_r    <= {RW{1'b0}};
            frame_done_r <= 1'b0;
        end else if (clk_en) begin
            if (frame_abort) begin
                // Abort wins over any handshake in the same cycle.
                state_r      <= IDLE;
                shadow_r     <= {SW{1'b0}};
                chunk_cnt_r  <= {CW{1'b0}};
                row_cnt_r    <= {RW{1'b0}};
                frame_done_r <= 1'b0;
            end else begin
                frame_done_r <= 1'b0;
                case (state_r)
                    IDLE: begin
                        if (row_valid) begin
                            shadow_r    <= SW'(row_mask);
                            chunk_cnt_r <= {CW{1'b0}};
                            state_r     <= SHIFT;
                        end else begin
                            state_r     <= IDLE;
                        end
                    end
                    SHIFT: begin
                        if (ser_ready) begin
                            shadow_r <= shadow_r >> OUT_W;
                            if (last_chunk_s) begin
                                chunk_cnt_r <= {CW{1'b0}};
                                state_r     <= IDLE;
                                if (last_row_s) begin
                                    row_cnt_r    <= {RW{1'b0}};
                                    frame_done_r <= 1'b1;
                                end else begin
                                    row_cnt_r    <= row_cnt_r + RW'(1);
                                end
                            end else begin
                                chunk_cnt_r <= chunk_cnt_r + CW'(1);
                                state_r     <= SHIFT;
                            end
                        end else begin
                            state_r <= SHIFT;
                        end
                    end
                    default: begin
                        state_r     <= IDLE;
                        shadow_r    <= {SW{1'b0}};
                        chunk_cnt_r <= {CW{1'b0}};
                    end
                endcase
            end
        end else begin
            state_r <= state_r;
        end
    end

endmodule

// File: tb/tb_mask_row_serializer.sv
// Directed bench for mask_row_serializer (IMG_W=300, IMG_H=4, OUT_W=16).
module tb_mask_row_serializer;

    localparam int IMG_W  = 300;
    localparam int IMG_H  = 4;
    localparam int OUT_W  = 16;
    localparam int NCHUNK = 19;

    logic             clk;
    logic             rst_n;
    logic             clk_en;
    logic             frame_abort;
    logic [IMG_W-1:0] row_mask;
    logic             row_valid;
    logic             row_ready;
    logic [OUT_W-1:0] ser_data;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_last_chunk;
    logic             ser_last_row;
    logic [1:0]       row_idx;
    logic             frame_done;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [IMG_W-1:0] mask_a;
    logic [IMG_W-1:0] mask_b;
    logic [IMG_W-1:0] mask_one;
    logic [IMG_W-1:0] mask_zero;
    logic [3:0]       nib;

    mask_row_serializer #(
        .IMG_W(IMG_W),
        .IMG_H(IMG_H),
        .OUT_W(OUT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clk_en(clk_en),
        .frame_abort(frame_abort),
        .row_mask(row_mask),
        .row_valid(row_valid),
        .row_ready(row_ready),
        .ser_data(ser_data),
        .ser_valid(ser_valid),
        .ser_ready(ser_ready),
        .ser_last_chunk(ser_last_chunk),
        .ser_last_row(ser_last_row),
        .row_idx(row_idx),
        .frame_done(frame_done),
        .busy(busy)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: sequence did not complete, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] beat_of(input logic [IMG_W-1:0] m, input int b);
        logic [NCHUNK*OUT_W-1:0] e;
        e = {4'b0000, m};
        return e[b*OUT_W +: OUT_W];
    endfunction

    // Send one row and check every beat. stall_beat<0 disables backpressure.
    task automatic run_row(input logic [IMG_W-1:0] m, input int row,
                           input int stall_beat, input int stall_len, input bit toggle);
        int cycles;
        int exp_cycles;
        row_mask  = m;
        row_valid = 1'b1;
        #1;
        check("row_ready_idle", 32'(row_ready), 32'd1);
        check("row_idx_idle", 32'(row_idx), 32'(row));
        @(posedge clk); #1;
        row_valid = 1'b0;
        cycles = 0;
        for (int b = 0; b < NCHUNK; b++) begin
            if (b == stall_beat) begin
                for (int s = 0; s < stall_len; s++) begin
                    ser_ready = 1'b0;
                    #1;
                    check("stall_valid", 32'(ser_valid), 32'd1);
                    check("stall_data", 32'(ser_data), 32'(beat_of(m, b)));
                    @(posedge clk); #1;
                    cycles++;
                end
            end
            ser_ready = 1'b1;
            if (toggle) begin
                clk_en = 1'b0;
                #1;
                check("dis_valid", 32'(ser_valid), 32'd0);
                check("dis_ready", 32'(row_ready), 32'd0);
                @(posedge clk); #1;
                cycles++;
                clk_en = 1'b1;
            end
            #1;
            check("beat_valid", 32'(ser_valid), 32'd1);
            check("beat_data", 32'(ser_data), 32'(beat_of(m, b)));
            check("last_chunk", 32'(ser_last_chunk), (b == NCHUNK - 1) ? 32'd1 : 32'd0);
            check("last_row", 32'(ser_last_row), (row == IMG_H - 1) ? 32'd1 : 32'd0);
            check("beat_row_ready", 32'(row_ready), 32'd0);
            check("beat_frame_done", 32'(frame_done), 32'd0);
            check("beat_row_idx", 32'(row_idx), 32'(row));
            @(posedge clk); #1;
            cycles++;
        end
        exp_cycles = NCHUNK + ((stall_beat >= 0) ? stall_len : 0) + (toggle ? NCHUNK : 0);
        check("row_cycles", 32'(cycles), 32'(exp_cycles));
        check("end_busy", 32'(busy), 32'd0);
        check("end_row_ready", 32'(row_ready), 32'd1);
        check("end_row_idx", 32'(row_idx), 32'((row + 1) % IMG_H));
        check("end_frame_done", 32'(frame_done), (row == IMG_H - 1) ? 32'd1 : 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        clk_en      = 1'b1;
        frame_abort = 1'b0;
        row_mask    = '0;
        row_valid   = 1'b0;
        ser_ready   = 1'b1;
        mask_a      = {75{4'b1010}};
        mask_one    = {IMG_W{1'b1}};
        mask_zero   = {IMG_W{1'b0}};
        for (int i = 0; i < 18; i++) mask_b[i*16 +: 16] = 16'h1100 + 16'(i);
        mask_b[299:288] = 12'h123;
        nib = 4'b0000;

        // Reset state.
        #1;
        check("rst_row_ready", 32'(row_ready), 32'd0);
        check("rst_ser_valid", 32'(ser_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_row_idx", 32'(row_idx), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_ser_data", 32'(ser_data), 32'd0);
        #12;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(row_ready), 32'd1);

        // Row 0: tiled 1010 pattern, no backpressure.
        check("pat_beat0", 32'(beat_of(mask_a, 0)), 32'h0000AAAA);
        run_row(mask_a, 0, -1, 0, 1'b0);

        // Row 1: three stall cycles on beat 5.
        run_row(mask_b, 1, 5, 3, 1'b0);

        // Row 2: abort at beat 10.
        row_mask  = mask_b;
        row_valid = 1'b1;
        #1;
        check("abort_ready", 32'(row_ready), 32'd1);
        @(posedge clk); #1;
        row_valid = 1'b0;
        for (int b = 0; b < 10; b++) begin
            #1;
            check("abort_pre_data", 32'(ser_data), 32'(beat_of(mask_b, b)));
            @(posedge clk); #1;
        end
        frame_abort = 1'b1;
        #1;
        check("abort_beat10", 32'(ser_data), 32'h0000110A);
        check("abort_last_row", 32'(ser_last_row), 32'd0);
        @(posedge clk); #1;
        frame_abort = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_row_idx", 32'(row_idx), 32'd0);
        check("abort_frame_done", 32'(frame_done), 32'd0);
        check("abort_ready_after", 32'(row_ready), 32'd1);
        check("abort_shadow", 32'(ser_data), 32'd0);

        // Full frame of four rows back to back, row k = all k[0].
        run_row(mask_zero, 0, -1, 0, 1'b0);
        run_row(mask_one, 1, -1, 0, 1'b0);
        run_row(mask_zero, 2, -1, 0, 1'b0);
        run_row(mask_one, 3, -1, 0, 1'b0);

        // Clock enable toggling every cycle; data must match the B pattern.
        run_row(mask_b, 0, -1, 0, 1'b1);

        // Asynchronous reset in the middle of a beat.
        row_mask  = mask_a;
        row_valid = 1'b1;
        @(posedge clk); #1;
        row_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            @(posedge clk); #1;
        end
        #2;
        check("pre_rst_valid", 32'(ser_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(ser_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_data", 32'(ser_data), 32'd0);
        check("arst_row_idx", 32'(row_idx), 32'd0);
        check("arst_ready", 32'(row_ready), 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_rel_ready", 32'(row_ready), 32'd1);
        check("arst_rel_idx", 32'(row_idx), 32'd0);
        check("arst_rel_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mask_row_serializer.md
Name: mask_row_serializer

Overview:
- Sits directly downstream of the repeated-pattern row generator.
- Accepts one IMG_W-bit row mask per handshake and streams it to the image-sensor mask shift chain in OUT_W-bit beats, LSB chunk first.
- Tracks row position within a frame of IMG_H rows and flags the last beat of each row and of each frame.

Parameters:
- IMG_W, 300, image sensor width in pixels (row mask width).
- IMG_H, 300, image sensor height in rows per frame.
- OUT_W, 16, serial beat width.
- Derived, not overridable: NCHUNK = ceil(IMG_W/OUT_W) (19 at defaults).
- Derived, not overridable: RW = max(1, clog2(IMG_H)) (9 at defaults).

Ports:
- clk  in  1  Single clock for the block; all state on rising edge.
- rst_n  in  1  Reset, asynchronous, active-low.
- clk_en  in  1  Clock enable; 0 freezes all state.
- frame_abort  in  1  Synchronous clear to IDLE with row counter 0.
- row_mask  in  IMG_W  Row mask from the pattern generator; bit 0 = pixel 0.
- row_valid  in  1  row_mask valid.
- row_ready  out  1  Block can accept a row.
- ser_data  out  OUT_W  Current beat; bit 0 = lowest pixel of the chunk.
- ser_valid  out  1  ser_data valid.
- ser_ready  in  1  Sensor chain accepts the beat.
- ser_last_chunk  out  1  Current beat is the final chunk of the row.
- ser_last_row  out  1  Current row is row IMG_H-1.
- row_idx  out  RW  Index of the row being sent, or of the next row when IDLE.
- frame_done  out  1  One-cycle pulse after the last beat of row IMG_H-1.
- busy  out  1  State is SHIFT.

Behaviour:
- Reset (async, rst_n=0): state IDLE; shadow register, chunk_cnt and row_cnt cleared; all outputs 0 except row_ready, which is 1 once rst_n=1 and clk_en=1.
- Shadow register is NCHUNK*OUT_W bits wide. On load, row_mask is zero-extended into it, so pad bits (IMG_W..NCHUNK*OUT_W-1) are 0. At defaults the last beat carries 12 valid bits plus 4 zero bits.
- State IDLE:
  - row_ready = clk_en.
  - On row_valid & row_ready: load shadow, chunk_cnt=0, go to SHIFT on the next cycle.
- State SHIFT:
  - ser_valid = clk_en; ser_data = shadow[OUT_W-1:0] (combinational from register).
  - On ser_valid & ser_ready:
    - shadow shifts right by OUT_W; chunk_cnt increments.
    - If chunk_cnt was NCHUNK-1: go to IDLE; row_cnt increments, wrapping IMG_H-1 -> 0; frame_done pulses the cycle after the wrap.
- row_ready is 0 in SHIFT, so there is exactly one bubble cycle between rows. Minimum row period is NCHUNK+1 cycles.
- ser_last_chunk = (state==SHIFT) & (chunk_cnt==NCHUNK-1).
- ser_last_row = (row_cnt==IMG_H-1).
- row_idx = row_cnt; busy = (state==SHIFT).
- Backpressure: while ser_valid=1 and ser_ready=0, ser_data and all counters hold. ser_valid stays asserted and never drops mid-row, except when clk_en=0.
- clk_en=0: row_ready and ser_valid are forced to 0, no state changes, frame_done is not asserted.
- frame_abort=1, only when clk_en=1: next state IDLE, row_cnt=0, chunk_cnt=0, shadow cleared, no frame_done. frame_abort has priority over a simultaneous handshake.
- Reset mid-row: the partial row is discarded and the frame restarts at row 0.
- row_valid is ignored in SHIFT. The upstream stage must hold row_mask stable until the handshake.

Test Plan:
- Default params, row_mask = 4'b1010 tiled 75 times, ser_ready=1 -> 19 beats: beats 0..17 = 0xAAAA, beat 18 = 0x0AAA with ser_last_chunk=1; row_ready high again 1 cycle after beat 18; row_idx 0 -> 1.
- Backpressure: ser_ready low for 3 cycles during beat 5 -> ser_data holds 0xAAAA and chunk_cnt holds 5; row completes in 22 cycles with no duplicated or lost beat.
- IMG_H=4, four rows back to back (row k = all bits k[0]) -> ser_last_row=1 only during row 3; frame_done pulses once, 1 cycle after row 3's last beat; row_idx wraps to 0.
- clk_en toggled 1/0 every cycle during a row -> ser_valid=0 on disabled cycles; exactly 19 beats transferred; data identical to the clk_en=1 case.
- frame_abort asserted at beat 10 of row 2 -> next cycle IDLE, row_idx=0, no frame_done; next row starts from a full 19-beat sequence.
- rst_n pulsed low asynchronously mid-beat -> outputs 0 immediately; after release row_ready=1 and row_idx=0.
